// File: rtl/pfm_job_scheduler_pkg.sv
// Shared definitions for the ProducePartialFM job scheduler.
//   - geometry of the input tile, kernels and output feature maps
//   - flattened bus widths derived from that geometry (Q1.15 words)
//   - scheduler state encoding
//   - kernel-set index wrapping helper
package pfm_job_scheduler_pkg;

    localparam int IP_SIZE = 6;
    localparam int K_SIZE  = 3;
    localparam int N_KSETS = 4;
    localparam int MIN_RUN = 2;
    localparam int WORD_W  = 16;

    function automatic int op_size(input int ip, input int k);
        return ip - k + 1;
    endfunction

    localparam int OP_SIZE = op_size(IP_SIZE, K_SIZE);

    localparam int IP_W = WORD_W * IP_SIZE * IP_SIZE;  // one input tile
    localparam int KW_W = WORD_W * K_SIZE * K_SIZE;    // one kernel
    localparam int KF_W = 3 * KW_W;                    // {K3f,K2f,K1f}
    localparam int OPW  = WORD_W * OP_SIZE * OP_SIZE;  // one output map
    localparam int IK_W = 3 * OPW;                     // {IK3,IK2,IK1}
    localparam int KS_W = (N_KSETS > 1) ? $clog2(N_KSETS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    // Out-of-range set indices (only possible when N_KSETS is not a power of two)
    // fold back into the bank.
    function automatic logic [KS_W-1:0] kset_wrap(input logic [KS_W-1:0] k);
        return KS_W'(32'(k) % N_KSETS);
    endfunction

endpackage

// File: rtl/pfm_job_scheduler_if.sv
// Signal bundle between the job scheduler and its surroundings.
//   job_*    : job offer port (valid/ready)
//   kw_*     : kernel bank write port
//   eng_*    : engine control / data
//   res_*    : result port (valid/ready)
//   busy, err_timeout : status
// slave  = scheduler side, master = environment side.
interface pfm_job_scheduler_if;
    import pfm_job_scheduler_pkg::*;

    logic            job_valid;
    logic            job_ready;
    logic [IP_W-1:0] job_ip;
    logic [KS_W-1:0] job_kset;

    logic            kw_en;
    logic [KS_W-1:0] kw_addr;
    logic [KF_W-1:0] kw_data;

    logic            eng_rst;
    logic [IP_W-1:0] eng_ipf;
    logic [KF_W-1:0] eng_kf;
    logic            eng_resting;
    logic [IK_W-1:0] eng_ik;

    logic            res_valid;
    logic            res_ready;
    logic [IK_W-1:0] res_fm;

    logic            busy;
    logic            err_timeout;

    modport slave (
        input  job_valid, job_ip, job_kset, kw_en, kw_addr, kw_data,
               eng_resting, eng_ik, res_ready,
        output job_ready, eng_rst, eng_ipf, eng_kf, res_valid, res_fm,
               busy, err_timeout
    );

    modport master (
        output job_valid, job_ip, job_kset, kw_en, kw_addr, kw_data,
               eng_resting, eng_ik, res_ready,
        input  job_ready, eng_rst, eng_ipf, eng_kf, res_valid, res_fm,
               busy, err_timeout
    );

endinterface

// File: rtl/pfm_job_scheduler_kernel_bank.sv
// Kernel bank: N_KSETS entries of one kernel set {K3f,K2f,K1f}.
//   clk, rst              : clock, synchronous active-low reset (clears all sets)
//   wr_en_i/wr_addr_i/wr_data_i : single write port
//   rd_addr_i / rd_data_o : asynchronous read port
module pfm_job_scheduler_kernel_bank
    import pfm_job_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic [KS_W-1:0] wr_addr_i,
    input  logic [KF_W-1:0] wr_data_i,
    input  logic [KS_W-1:0] rd_addr_i,
    output logic [KF_W-1:0] rd_data_o
);

    logic [KF_W-1:0] mem_q [N_KSETS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_KSETS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[kset_wrap(wr_addr_i)] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[kset_wrap(rd_addr_i)];

endmodule

// File: rtl/pfm_job_scheduler.sv
// Job scheduler for the ProducePartialFM convolution engine.
// Takes a job (input tile + kernel-set index), loads the engine, releases it from
// reset, waits for a fresh resting flag and returns IK1..IK3 on the result port.
//   clk, rst  : clock, synchronous active-low reset
//   pfm_io    : pfm_job_scheduler_if.slave (job, kernel write, engine, result, status)
// Optional build macro: PFM_WATCHDOG_EN -- bounds RUN to TIMEOUT_CYC cycles and
// raises a sticky err_timeout; without it RUN waits indefinitely.
//
// state | meaning
// IDLE  | job_ready=1, engine held in reset
// LOAD  | tile and kernel copy presented, engine still in reset
// RUN   | engine released, waiting for an armed resting flag
// DONE  | result held on res_fm until res_ready
module pfm_job_scheduler #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    pfm_job_scheduler_if.slave pfm_io
);
    import pfm_job_scheduler_pkg::*;

    localparam int              CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);

    state_e           state_q;
    logic             job_ready_q;
    logic             eng_rst_q;
    logic             res_valid_q;
    logic             busy_q;
    logic             armed_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic [IP_W-1:0]  ip_q;
    logic [KF_W-1:0]  kf_q;
    logic [IK_W-1:0]  res_fm_q;
    logic [KF_W-1:0]  bank_rd;
    logic             run_mature;
    logic             rest_ok;

`ifdef PFM_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic err_q;
`endif

    pfm_job_scheduler_kernel_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (pfm_io.kw_en),
        .wr_addr_i (pfm_io.kw_addr),
        .wr_data_i (pfm_io.kw_data),
        .rd_addr_i (pfm_io.job_kset),
        .rd_data_o (bank_rd)
    );

    // A resting flag counts only after MIN_RUN cycles and after it has been seen
    // low at least once, so a flag left high from a previous job is not taken.
    assign run_mature = (run_cnt_q >= MIN_RUN_C);
    assign rest_ok    = run_mature && armed_q && pfm_io.eng_resting;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            job_ready_q <= 1'b1;
            eng_rst_q   <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            run_cnt_q   <= '0;
            ip_q        <= '0;
            kf_q        <= '0;
            res_fm_q    <= '0;
`ifdef PFM_WATCHDOG_EN
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Kernel copy is taken here so a same-edge bank write is not seen
                    // and later writes to this set cannot disturb a running job.
                    if (pfm_io.job_valid && job_ready_q) begin
                        ip_q        <= pfm_io.job_ip;
                        kf_q        <= bank_rd;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    eng_rst_q <= 1'b0;
                    run_cnt_q <= '0;
                    armed_q   <= 1'b0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_cnt_q != CNT_MAX) begin
                        run_cnt_q <= run_cnt_q + 1'b1;
                    end
                    if (rest_ok) begin
                        res_fm_q    <= pfm_io.eng_ik;
                        eng_rst_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`ifdef PFM_WATCHDOG_EN
                    else if (run_cnt_q == TO_LAST) begin
                        res_fm_q    <= '0;
                        err_q       <= 1'b1;
                        eng_rst_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`endif
                    else if (run_mature && !pfm_io.eng_resting) begin
                        armed_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (pfm_io.res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pfm_io.job_ready = job_ready_q;
    assign pfm_io.eng_rst   = eng_rst_q;
    assign pfm_io.eng_ipf   = ip_q;
    assign pfm_io.eng_kf    = kf_q;
    assign pfm_io.res_valid = res_valid_q;
    assign pfm_io.res_fm    = res_fm_q;
    assign pfm_io.busy      = busy_q;
`ifdef PFM_WATCHDOG_EN
    assign pfm_io.err_timeout = err_q;
`else
    assign pfm_io.err_timeout = 1'b0;
`endif

endmodule
